// File: rtl/pipe_add_pkg.sv
// Shared configuration helpers and beat control types for the pipelined CLA adder.
// Parameter legality and slice/group geometry are derived here so every module agrees.
package pipe_add_pkg;

  typedef struct packed {
    logic sub;
    logic sat;
  } beat_ctl_t;

  function automatic bit cfg_ok(input int width, input int stages, input int block);
    if (width <= 0 || stages <= 0 || block <= 0) return 1'b0;
    if (width % stages != 0) return 1'b0;
    if ((width / stages) % block != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int slice_w(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic int group_cnt(input int slice, input int block);
    return (block > 0) ? slice / block : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder for one pipeline slice, built from BLOCK-wide groups.
// Carries are fully flattened: group carries look ahead over all lower groups, bit carries over the group.
module cla_slice
  import pipe_add_pkg::*;
#(
  parameter int SLICE = 8,
  parameter int BLOCK = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int NG = group_cnt(SLICE, BLOCK);

  if (BLOCK <= 0 || SLICE % BLOCK != 0) begin : g_cfg_err
    $error("cla_slice: SLICE=%0d is not a multiple of BLOCK=%0d", SLICE, BLOCK);
  end

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin : grp_pg
    logic gt;
    logic pt;
    gt    = 1'b0;
    pt    = 1'b1;
    grp_g = '0;
    grp_p = '0;
    for (int n = 0; n < NG; n++) begin
      gt = 1'b0;
      pt = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        gt = g[n*BLOCK+j] | (p[n*BLOCK+j] & gt);
        pt = pt & p[n*BLOCK+j];
      end
      grp_g[n] = gt;
      grp_p[n] = pt;
    end
  end

  // Each group carry is a sum-of-products over all lower groups plus cin.
  always_comb begin : grp_carry
    logic ct;
    logic pr;
    ct       = 1'b0;
    pr       = 1'b1;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int n = 0; n < NG; n++) begin
      ct = grp_g[n];
      pr = grp_p[n];
      for (int m = n - 1; m >= 0; m--) begin
        ct = ct | (pr & grp_g[m]);
        pr = pr & grp_p[m];
      end
      grp_c[n+1] = ct | (pr & cin);
    end
  end

  always_comb begin : bit_carry
    logic ct;
    logic pr;
    ct = 1'b0;
    pr = 1'b1;
    c  = '0;
    for (int n = 0; n < NG; n++) begin
      for (int j = 0; j < BLOCK; j++) begin
        ct = 1'b0;
        pr = 1'b1;
        for (int m = j - 1; m >= 0; m--) begin
          ct = ct | (pr & g[n*BLOCK+m]);
          pr = pr & p[n*BLOCK+m];
        end
        c[n*BLOCK+j] = ct | (pr & grp_c[n]);
      end
    end
  end

  assign sum   = p ^ c;
  assign cout  = grp_c[NG];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES slice per stage, STAGES-cycle latency, global stall on out_ready.
// Optional signed saturation of the result is built when PIPE_CLA_ADDER_SAT_EN is defined.
module pipe_cla_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPE_CLA_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_err
    $error("pipe_cla_adder: illegal WIDTH=%0d STAGES=%0d BLOCK=%0d", WIDTH, STAGES, BLOCK);
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    beat_ctl_t        ctl;
  } beat_t;

  beat_t            in_beat;
  logic             advance;
  logic             fin_v;
  logic             fin_co;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sum;
  logic [WIDTH-1:0] res_sum;

  assign advance      = !out_valid || out_ready;
  assign in_ready     = advance;
  assign in_beat.a    = a;
  assign in_beat.b    = b;
  assign in_beat.ctl.sub = sub;
`ifdef PIPE_CLA_ADDER_SAT_EN
  assign in_beat.ctl.sat = sat;
  logic fin_sat;
`else
  assign in_beat.ctl.sat = 1'b0;
`endif

  // Stage k register: a_q holds finished sum slices below k and raw operand A above;
  // b_q already carries the subtract inversion, so the slice only ever adds.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             v_d;
    logic             c_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] a_nx;
    logic [SLICE-1:0] s;
    logic             co;
    logic             cm;
`ifdef PIPE_CLA_ADDER_SAT_EN
    logic             sat_q;
    logic             sat_d;
`endif

    if (k == 0) begin : g_src
      assign v_d = in_valid;
      assign a_d = in_beat.a;
      assign b_d = in_beat.ctl.sub ? ~in_beat.b : in_beat.b;
      assign c_d = in_beat.ctl.sub | cin;
`ifdef PIPE_CLA_ADDER_SAT_EN
      assign sat_d = in_beat.ctl.sat;
`endif
    end else begin : g_src
      assign v_d = g_stage[k-1].v_q;
      assign a_d = g_stage[k-1].a_nx;
      assign b_d = g_stage[k-1].b_q;
      assign c_d = g_stage[k-1].co;
`ifdef PIPE_CLA_ADDER_SAT_EN
      assign sat_d = g_stage[k-1].sat_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_d;
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
`ifdef PIPE_CLA_ADDER_SAT_EN
        sat_q <= sat_d;
`endif
      end
    end

    cla_slice #(
      .SLICE(SLICE),
      .BLOCK(BLOCK)
    ) u_slice (
      .a    (a_q[k*SLICE +: SLICE]),
      .b    (b_q[k*SLICE +: SLICE]),
      .cin  (c_q),
      .sum  (s),
      .cout (co),
      .c_msb(cm)
    );

    always_comb begin
      a_nx = a_q;
      a_nx[k*SLICE +: SLICE] = s;
    end

    if (k == STAGES - 1) begin : g_fin
      assign fin_v   = v_q;
      assign fin_sum = a_nx;
      assign fin_co  = co;
      assign fin_ovf = co ^ cm;
`ifdef PIPE_CLA_ADDER_SAT_EN
      assign fin_sat = sat_q;
`endif
    end
  end

`ifdef PIPE_CLA_ADDER_SAT_EN
  // On overflow the wrapped MSB is the inverse of the true sign.
  always_comb begin
    res_sum = fin_sum;
    if (fin_sat && fin_ovf) begin
      res_sum = fin_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign res_sum = fin_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_v;
      if (fin_v) begin
        sum  <= res_sum;
        cout <= fin_co;
        ovf  <= fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed bench for pipe_cla_adder: STAGES=4 main instance plus STAGES=1 and STAGES=8 latency instances.
module tb_pipe_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, cin, sub, sat_i, out_ready, rdy_one;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [31:0] sum1;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [31:0] sum8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [33:0] got[$];
  int          got_cyc[$];

  logic [31:0] va_tab[8];
  logic [31:0] vb_tab[8];
  logic        vc_tab[8];
  logic        vs_tab[8];
  logic [33:0] exp_tab[8];

  pipe_cla_adder #(.WIDTH(32), .STAGES(4), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PIPE_CLA_ADDER_SAT_EN
    .sat(sat_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_cla_adder #(.WIDTH(32), .STAGES(1), .BLOCK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PIPE_CLA_ADDER_SAT_EN
    .sat(sat_i),
`endif
    .out_valid(out_valid1), .out_ready(rdy_one), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  pipe_cla_adder #(.WIDTH(32), .STAGES(8), .BLOCK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PIPE_CLA_ADDER_SAT_EN
    .sat(sat_i),
`endif
    .out_valid(out_valid8), .out_ready(rdy_one), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake completes on the next rising edge; out_ready only changes just after rising edges.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      got.push_back({sum, cout, ovf});
      got_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                      input logic vs, input logic vsat);
    logic ok;
    ok = 1'b0;
    a = va; b = vb; cin = vc; sub = vs; sat_i = vsat; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("send_accepted", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int t = 0; t < 60 && got.size() < n; t++) @(posedge clk);
    #1;
  endtask

  task automatic lat_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic vs, input logic [33:0] exp);
    int          l4, l1, l8;
    logic [33:0] r4, r1, r8;
    l4 = -1; l1 = -1; l8 = -1;
    r4 = '0; r1 = '0; r8 = '0;
    a = va; b = vb; cin = vc; sub = vs; sat_i = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid  && l4 < 0) begin l4 = n; r4 = {sum,  cout,  ovf};  end
      if (out_valid1 && l1 < 0) begin l1 = n; r1 = {sum1, cout1, ovf1}; end
      if (out_valid8 && l8 < 0) begin l8 = n; r8 = {sum8, cout8, ovf8}; end
    end
    check_eq({tag, "_lat_s4"}, 64'(l4), 64'd4);
    check_eq({tag, "_lat_s1"}, 64'(l1), 64'd1);
    check_eq({tag, "_lat_s8"}, 64'(l8), 64'd8);
    check_eq({tag, "_res_s4"}, {30'd0, r4}, {30'd0, exp});
    check_eq({tag, "_res_s1"}, {30'd0, r1}, {30'd0, exp});
    check_eq({tag, "_res_s8"}, {30'd0, r8}, {30'd0, exp});
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    va_tab[0] = 32'h00000001; vb_tab[0] = 32'h00000002; vc_tab[0] = 0; vs_tab[0] = 0; exp_tab[0] = {32'h00000003, 1'b0, 1'b0};
    va_tab[1] = 32'hFFFFFFFF; vb_tab[1] = 32'hFFFFFFFF; vc_tab[1] = 1; vs_tab[1] = 0; exp_tab[1] = {32'hFFFFFFFF, 1'b1, 1'b0};
    va_tab[2] = 32'h80000000; vb_tab[2] = 32'h80000000; vc_tab[2] = 0; vs_tab[2] = 0; exp_tab[2] = {32'h00000000, 1'b1, 1'b1};
    va_tab[3] = 32'h00000010; vb_tab[3] = 32'h00000001; vc_tab[3] = 1; vs_tab[3] = 1; exp_tab[3] = {32'h0000000F, 1'b1, 1'b0};
    va_tab[4] = 32'h0000FFFF; vb_tab[4] = 32'h00000001; vc_tab[4] = 0; vs_tab[4] = 0; exp_tab[4] = {32'h00010000, 1'b0, 1'b0};
    va_tab[5] = 32'h80000000; vb_tab[5] = 32'h00000001; vc_tab[5] = 0; vs_tab[5] = 1; exp_tab[5] = {32'h7FFFFFFF, 1'b1, 1'b1};
    va_tab[6] = 32'h12345678; vb_tab[6] = 32'h11111111; vc_tab[6] = 0; vs_tab[6] = 0; exp_tab[6] = {32'h23456789, 1'b0, 1'b0};
    va_tab[7] = 32'h00000000; vb_tab[7] = 32'h00000000; vc_tab[7] = 1; vs_tab[7] = 0; exp_tab[7] = {32'h00000001, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat_i = 1'b0;
    out_ready = 1'b1; rdy_one = 1'b1;
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_sum", {32'd0, sum}, 64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    lat_vec("carry_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0});
    lat_vec("sub_borrow", 32'h00000003, 32'h00000005, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0});

    // Back-to-back beats with sub toggling between them.
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    send(32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0);
    wait_got(2);
    check_eq("b2b_count", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      check_eq("b2b_beat0", {30'd0, got[0]}, {30'd0, 32'h80000000, 1'b0, 1'b1});
      check_eq("b2b_beat1", {30'd0, got[1]}, {30'd0, 32'h00000002, 1'b1, 1'b0});
      check_eq("b2b_spacing", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
    end
    repeat (4) @(posedge clk);
    #1;
    got.delete();
    got_cyc.delete();

    // Eight-beat stream with a three-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send(va_tab[i], vb_tab[i], vc_tab[i], vs_tab[i], 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          int idx;
          @(negedge clk);
          idx = (got.size() > 7) ? 7 : got.size();
          check_eq($sformatf("hold%0d_out_valid", h), {63'd0, out_valid}, 64'd1);
          check_eq($sformatf("hold%0d_in_ready", h), {63'd0, in_ready}, 64'd0);
          check_eq($sformatf("hold%0d_result", h), {30'd0, sum, cout, ovf}, {30'd0, exp_tab[idx]});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_got(8);
    repeat (6) @(posedge clk);
    #1;
    check_eq("stream_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("stream_beat%0d", i),
               (i < got.size()) ? {30'd0, got[i]} : 64'hBAD0_BAD0_BAD0_BAD0,
               {30'd0, exp_tab[i]});
    end
    got.delete();
    got_cyc.delete();

    // Reset between edges while results are in flight.
    send(va_tab[0], vb_tab[0], vc_tab[0], vs_tab[0], 1'b0);
    send(va_tab[5], vb_tab[5], vc_tab[5], vs_tab[5], 1'b0);
    send(va_tab[6], vb_tab[6], vc_tab[6], vs_tab[6], 1'b0);
    for (int t = 0; t < 10 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_sum", {32'd0, sum}, 64'd0);
    check_eq("midrst_cout", {63'd0, cout}, 64'd0);
    check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_stale_results", 64'(got.size()), 64'd0);
    check_eq("no_stale_valid", {63'd0, out_valid}, 64'd0);
    got.delete();
    got_cyc.delete();

`ifdef PIPE_CLA_ADDER_SAT_EN
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    send(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    wait_got(3);
    check_eq("sat_count", 64'(got.size()), 64'd3);
    if (got.size() >= 3) begin
      check_eq("sat_pos_clamp", {30'd0, got[0]}, {30'd0, 32'h7FFFFFFF, 1'b0, 1'b1});
      check_eq("sat_neg_clamp", {30'd0, got[1]}, {30'd0, 32'h80000000, 1'b1, 1'b1});
      check_eq("sat_off_wrap", {30'd0, got[2]}, {30'd0, 32'h80000000, 1'b0, 1'b1});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
